// File: rtl/keypad_pkg.sv
// Shared types and the keypad matrix map for the keypad front end.
// Pure definitions: no state and no latency.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAND    = 2'd1,
        PRESSED = 2'd2,
        REL     = 2'd3
    } db_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } sweep_kind_t;

    // Physical (row, column) position to key code; * and # take the two spare codes.
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'h0;
            4'hE:    code = KEY_HASH;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency 2 cycles; no flow control, samples every cycle.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with per-sweep debounce, ghost rejection and no auto-repeat.
// Strobe lands DB_COUNT sweeps + 1 cycle after rows settle; no backpressure, key held until next press.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 27000,
    parameter int DB_COUNT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_pressed,
    output logic       key_strobe
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DB_COUNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DB_COUNT);

    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0][3:0]  cap_q, cap_d;
    logic             sweep_end_q, sweep_end_d;
    db_state_t        state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic             key_pressed_q, key_pressed_d;
    logic             key_strobe_q, key_strobe_d;

    logic             div_last;
    logic [4:0]       n_low;
    logic [3:0]       hit_code;
    sweep_kind_t      sweep_kind;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_sync)
    );

    assign div_last = (div_q == DIV_LAST);
    assign col      = ~(4'b0001 << col_idx_q);

    // Rows are captured on the last divider cycle of each column, long after the synchroniser settles.
    always_comb begin
        div_d       = div_last ? '0 : div_q + DIV_W'(1);
        col_idx_d   = div_last ? col_idx_q + 2'd1 : col_idx_q;
        cap_d       = cap_q;
        if (div_last) begin
            cap_d[col_idx_q] = row_sync;
        end
        sweep_end_d = div_last && (col_idx_q == 2'd3);
    end

    always_comb begin
        n_low    = '0;
        hit_code = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!cap_q[c][r]) begin
                    n_low    = n_low + 5'd1;
                    hit_code = keymap(2'(r), 2'(c));
                end
            end
        end
        if (n_low == 5'd0) begin
            sweep_kind = NONE;
        end else if (n_low == 5'd1) begin
            sweep_kind = SINGLE;
        end else begin
            sweep_kind = MULTI;
        end
    end

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        key_d         = key_q;
        key_pressed_d = key_pressed_q;
        key_strobe_d  = 1'b0;
        if (sweep_end_q) begin
            case (state_q)
                IDLE: begin
                    if (sweep_kind == SINGLE) begin
                        state_d = CAND;
                        cand_d  = hit_code;
                        cnt_d   = CNT_ONE;
                    end
                end
                CAND: begin
                    if (sweep_kind == SINGLE && hit_code == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d       = PRESSED;
                            cnt_d         = CNT_FULL;
                            key_d         = cand_q;
                            key_pressed_d = 1'b1;
                            key_strobe_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (sweep_kind == SINGLE) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                // Anything but a clean release is ignored: roll-over needs all keys up first.
                PRESSED: begin
                    if (sweep_kind == NONE) begin
                        state_d = REL;
                        cnt_d   = CNT_ONE;
                    end
                end
                REL: begin
                    if (sweep_kind == NONE) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d       = IDLE;
                            cnt_d         = '0;
                            key_pressed_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = CNT_FULL;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            col_idx_q     <= '0;
            cap_q         <= '1;
            sweep_end_q   <= 1'b0;
            state_q       <= IDLE;
            cand_q        <= '0;
            cnt_q         <= '0;
            key_q         <= '0;
            key_pressed_q <= 1'b0;
            key_strobe_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_idx_q     <= col_idx_d;
            cap_q         <= cap_d;
            sweep_end_q   <= sweep_end_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            key_q         <= key_d;
            key_pressed_q <= key_pressed_d;
            key_strobe_q  <= key_strobe_d;
        end
    end

    assign key         = key_q;
    assign key_pressed = key_pressed_q;
    assign key_strobe  = key_strobe_q;

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage of the calculator datapath: scans the 4x4 matrix keypad, synchronises and debounces the rows, and resolves one key code per valid press.
- Outputs a level `key_pressed` and a one-cycle `key_strobe`; the calculator control FSM consumes `key` on `key_strobe`.
- Rejects multi-key (ghost) presses and suppresses auto-repeat.

Parameters:
- SCAN_DIV, 27000: clk cycles each column is driven (1 ms at 27 MHz); minimum 4.
- DB_COUNT, 5: consecutive identical full sweeps required to accept a press or a release; minimum 2.

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  asynchronous reset, active-low
- row  in  4  keypad rows, active-low (pulled up), asynchronous to clk
- col  out  4  keypad columns, active-low one-hot drive
- key  out  4  code of the accepted key, held until the next accepted press
- key_pressed  out  1  high while a debounced key is held
- key_strobe  out  1  one-cycle pulse per accepted press

Behaviour:
- Reset (rst=0, async) values:
  - col=4'b1110, key=4'h0, key_pressed=0, key_strobe=0.
  - FSM in IDLE; divider, column index and debounce count cleared.
- Synchroniser: row passes through a 2-flop synchroniser; only the synchronised value is used.
- Column scan:
  - div counts 0..SCAN_DIV-1 and free-runs in every FSM state.
  - col index c advances 0->1->2->3->0 on the edge after div==SCAN_DIV-1.
  - col = ~(1<<c).
- Row sampling: on the cycle div==SCAN_DIV-1, the synchronised rows are captured for column c.
  - This gives SCAN_DIV-1 cycles of settle time, which covers the 2-cycle synchroniser.
- Sweep end: one cycle after the column-3 sample. Sweep period = 4*SCAN_DIV cycles.
- Sweep result, classified from 16 captured bits:
  - NONE: no bits low.
  - SINGLE(code): exactly one bit low.
  - MULTI: two or more bits low.
- Keymap, (row,col) -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
  - Digits map to their BCD value; A-D map to 4'hA-4'hD.
- Debounce FSM. It is evaluated only at sweep end; cnt saturates at DB_COUNT.
  - IDLE:
    - SINGLE(k) -> CAND, with cand=k, cnt=1.
    - NONE or MULTI -> stay.
  - CAND:
    - SINGLE(cand) -> cnt+1. When cnt reaches DB_COUNT -> PRESSED.
    - On entry to PRESSED, in the same edge: key<=cand, key_pressed<=1, key_strobe<=1 for exactly one cycle.
    - SINGLE(other) -> stay in CAND, with cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - NONE -> REL, with cnt=1.
    - SINGLE (any code) or MULTI -> stay. No new strobe and key is unchanged: a roll-over needs a full release first.
  - REL:
    - NONE -> cnt+1. When cnt reaches DB_COUNT -> IDLE, and key_pressed<=0 on that edge.
    - SINGLE or MULTI -> PRESSED, with no strobe (bounce on release).
- Timing:
  - key_strobe is never high on two consecutive cycles.
  - key_strobe is at most one pulse per press/release cycle.
  - key is stable on the strobe cycle and afterwards.
- Latency: from rows stable at the start of sweep n to the strobe is DB_COUNT sweeps + 1 cycle.
- Reset mid-press: all outputs return to reset values immediately. After rst rises, a key still held must pass a full CAND qualification, then strobes once.
- Invalid FSM encoding -> IDLE.

Decomposition:
- Package keypad_pkg:
  - KEY_STAR=4'hE and KEY_HASH=4'hF.
  - Typedef db_state_t {IDLE, CAND, PRESSED, REL}.
  - Typedef sweep_kind_t {NONE, SINGLE, MULTI}.
  - Function keymap(row_idx, col_idx) returning the 4-bit code.
- One sub-module, sync_2ff (parameterised width), for the row synchroniser. The rest stays flat.

Test Plan (SCAN_DIV=4, DB_COUNT=3; sweep = 16 cycles):
1. Reset then idle:
   - Rows all 1 for 200 cycles -> col cycles 1110, 1101, 1011, 0111 every 4 cycles.
   - key_pressed=0 and key_strobe never asserted throughout.
2. Clean press of '5' (row1 low while col1 is driven), held 10 sweeps:
   - Exactly one key_strobe, 3 sweeps + 1 cycle after the first full sweep in which the key is seen; key=4'h5.
   - key_pressed stays 1 until 3 NONE sweeps after release.
3. Bouncy press of '#':
   - Toggle row3 every 3 cycles during col2 for 2 sweeps, then hold -> single strobe with key=4'hF.
   - No strobe during the bounce.
4. Two keys at once, '1' and '2' (row0 during col0 and col1) -> no strobe ever; key keeps its prior value.
5. Hold '7' and add '8' while in PRESSED, release '7' only -> no second strobe; key stays 4'h7 until all keys are released.
6. Press '*' to accepted, assert rst=0 for 3 cycles mid-hold, keep holding:
   - Outputs are at reset values immediately.
   - Exactly one new strobe with key=4'hE after requalification.
